// File: rtl/series_arbiter.sv
// series_arbiter: round-robin scheduler sharing one in-order pipelined
// series-evaluation engine between NREQ requesters. Each issued operand's
// requester tag is queued in issue order so results can be routed back.
module series_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               flush,
    input  logic               eng_ready,
    output logic               eng_start,
    output logic [DW-1:0]      eng_x,
    input  logic               eng_out_valid,
    input  logic [DW-1:0]      eng_result,
    input  logic               eng_error,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_error,
    output logic               busy,
    output logic               protocol_err
);

    localparam int TW = $clog2(NREQ);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [TW-1:0]   tag_mem_q [DEPTH];

    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_error_q, rsp_error_d;
    logic            protocol_err_q, protocol_err_d;

    logic            grant_found;
    logic [TW-1:0]   grant_idx;
    logic [TW-1:0]   cand_idx;
    logic [TW-1:0]   head_tag;
    logic            full, pop, issue_ok, push;

    assign head_tag = tag_mem_q[rd_q];
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = eng_out_valid && (count_q != '0);
    // A full FIFO may still accept a push when the head is popped this cycle.
    assign issue_ok = (state_q != DRAIN) && !flush && eng_ready && (!full || pop);
    assign push     = issue_ok && grant_found;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = ptr_q + TW'(k);  // NREQ is a power of two, so this wraps naturally
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Grant and engine-issue outputs, combinational for zero-latency issue.
    always_comb begin
        req_ready = '0;
        eng_x     = '0;
        if (push) begin
            req_ready = NREQ'(1) << grant_idx;
            eng_x     = req_data[grant_idx*DW +: DW];
        end
    end

    assign eng_start = push;

    // Tag FIFO bookkeeping, round-robin pointer and response capture.
    always_comb begin
        ptr_d          = push ? grant_idx + TW'(1) : ptr_q;
        count_d        = count_q + CW'(push) - CW'(pop);
        wr_d           = wr_q;
        rd_d           = rd_q;
        rsp_valid_d    = '0;
        rsp_data_d     = rsp_data_q;
        rsp_error_d    = rsp_error_q;
        protocol_err_d = protocol_err_q | (eng_out_valid && (count_q == '0));
        if (push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
        if (pop) begin
            rd_d        = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
            rsp_valid_d = NREQ'(1) << head_tag;
            rsp_data_d  = eng_result;
            rsp_error_d = eng_error;
        end
    end

    // Scheduler state: IDLE with nothing queued, RUN while issuing, DRAIN after flush.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush)     state_d = (count_d != '0) ? DRAIN : IDLE;
                else if (push) state_d = RUN;
            end
            RUN: begin
                if (flush)                state_d = (count_d != '0) ? DRAIN : IDLE;
                else if (count_d == '0)   state_d = IDLE;
            end
            DRAIN: begin
                if (count_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            count_q        <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            rsp_error_q    <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            count_q        <= count_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_error_q    <= rsp_error_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Tag storage.
    // NOTE: the tag array is not reset; entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_q] <= grant_idx;
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_error    = rsp_error_q;
    assign protocol_err = protocol_err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_series_arbiter.sv
// Directed bench for series_arbiter: expected grants are written per step,
// issued tags and engine results go through a scoreboard queue.
module tb_series_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               flush;
    logic               eng_ready;
    logic               eng_start;
    logic [DW-1:0]      eng_x;
    logic               eng_out_valid;
    logic [DW-1:0]      eng_result;
    logic               eng_error;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_error;
    logic               busy;
    logic               protocol_err;

    series_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .flush        (flush),
        .eng_ready    (eng_ready),
        .eng_start    (eng_start),
        .eng_x        (eng_x),
        .eng_out_valid(eng_out_valid),
        .eng_result   (eng_result),
        .eng_error    (eng_error),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    typedef struct {
        int            tag;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    int   tests = 0;
    int   fails = 0;
    int   tag_q [$];
    rsp_t exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Advance one clock; then compare the registered response against the scoreboard.
    task automatic cycle(input string name);
        rsp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, " rsp_valid"}, 64'(rsp_valid), 64'(NREQ'(1) << e.tag));
            check({name, " rsp_data"},  64'(rsp_data),  64'(e.data));
            check({name, " rsp_error"}, 64'(rsp_error), 64'(e.err));
        end else begin
            check({name, " rsp_idle"}, 64'(rsp_valid), 64'(0));
        end
    endtask

    // Drive one cycle of stimulus, check the combinational grant, update scoreboard.
    task automatic drive(input string name, input logic [NREQ-1:0] rv, input logic [DW-1:0] base,
                         input logic rdy, input logic fl, input logic ov, input logic [DW-1:0] res,
                         input logic err, input logic [NREQ-1:0] exp_grant);
        logic [DW-1:0] exp_x;
        rsp_t          e;
        req_valid = rv;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = base + DW'(i * 16);
        eng_ready     = rdy;
        flush         = fl;
        eng_out_valid = ov;
        eng_result    = res;
        eng_error     = err;
        #1;
        exp_x = '0;
        for (int i = 0; i < NREQ; i++) if (exp_grant[i]) exp_x = base + DW'(i * 16);
        check({name, " req_ready"}, 64'(req_ready), 64'(exp_grant));
        check({name, " eng_start"}, 64'(eng_start), 64'(|exp_grant));
        check({name, " eng_x"},     64'(eng_x),     64'(exp_x));
        if (ov && tag_q.size() > 0) begin
            e.tag  = tag_q.pop_front();
            e.data = res;
            e.err  = err;
            exp_q.push_back(e);
        end
        for (int i = 0; i < NREQ; i++) if (exp_grant[i]) tag_q.push_back(i);
        cycle(name);
    endtask

    task automatic do_reset();
        req_valid = '0; req_data = '0; flush = 0; eng_ready = 0;
        eng_out_valid = 0; eng_result = '0; eng_error = 0;
        rst_n = 1'b0;
        tag_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("reset rsp_valid",    64'(rsp_valid),    64'(0));
        check("reset rsp_data",     64'(rsp_data),     64'(0));
        check("reset rsp_error",    64'(rsp_error),    64'(0));
        check("reset protocol_err", 64'(protocol_err), 64'(0));
        check("reset busy",         64'(busy),         64'(0));

        // Single request, result 3 cycles after issue
        drive("single issue", 4'b0001, 16'h0100, 1, 0, 0, '0, 0, 4'b0001);
        drive("single wait1", 4'b0000, 16'h0100, 1, 0, 0, '0, 0, 4'b0000);
        drive("single wait2", 4'b0000, 16'h0100, 1, 0, 0, '0, 0, 4'b0000);
        check("single busy", 64'(busy), 64'(1));
        drive("single result", 4'b0000, 16'h0100, 1, 0, 1, 16'h02B8, 0, 4'b0000);
        check("single busy fall", 64'(busy), 64'(0));

        // Round-robin filling the FIFO to DEPTH
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            drive("rr issue", 4'b1111, 16'h2000, 1, 0, 0, '0, 0, NREQ'(1) << (i % NREQ));
        drive("full block", 4'b1111, 16'h2000, 1, 0, 0, '0, 0, 4'b0000);
        drive("full pop+issue", 4'b1111, 16'h2000, 1, 0, 1, 16'h3000, 0, 4'b0001);
        for (int i = 0; i < DEPTH; i++)
            drive("rr result", 4'b0000, 16'h2000, 1, 0, 1, 16'h3100 + DW'(i), 0, 4'b0000);
        check("rr drained busy", 64'(busy), 64'(0));

        // Wrap-around search from ptr=1
        drive("wrap a", 4'b1001, 16'h4000, 1, 0, 0, '0, 0, 4'b1000);
        drive("wrap b", 4'b1001, 16'h4000, 1, 0, 0, '0, 0, 4'b0001);
        drive("wrap c", 4'b0001, 16'h4000, 1, 0, 0, '0, 0, 4'b0001);
        drive("no eng_ready", 4'b1111, 16'h4000, 0, 0, 0, '0, 0, 4'b0000);
        for (int i = 0; i < 3; i++)
            drive("wrap result", 4'b0000, 16'h4000, 1, 0, 1, 16'h4100 + DW'(i), 0, 4'b0000);

        // Flush with 3 in flight; last result carries an error for tag 2
        do_reset();
        for (int i = 0; i < 3; i++)
            drive("flush fill", 4'b1111, 16'h5000, 1, 0, 0, '0, 0, NREQ'(1) << i);
        drive("flush pulse", 4'b1111, 16'h5000, 1, 1, 0, '0, 0, 4'b0000);
        check("drain busy", 64'(busy), 64'(1));
        drive("drain r0", 4'b1111, 16'h5000, 1, 0, 1, 16'h5A00, 0, 4'b0000);
        drive("drain r1", 4'b1111, 16'h5000, 1, 0, 1, 16'h5A01, 0, 4'b0000);
        drive("drain r2 err", 4'b1111, 16'h5000, 1, 0, 1, 16'h5A02, 1, 4'b0000);
        check("drain idle busy", 64'(busy), 64'(0));
        drive("post drain", 4'b1111, 16'h5000, 1, 0, 0, '0, 0, 4'b1000);
        drive("post result", 4'b0000, 16'h5000, 1, 0, 1, 16'h5B00, 0, 4'b0000);
        drive("flush empty", 4'b1111, 16'h5000, 1, 1, 0, '0, 0, 4'b0000);
        check("flush empty busy", 64'(busy), 64'(0));

        // Result with empty FIFO
        drive("orphan result", 4'b0000, 16'h0000, 1, 0, 1, 16'h1234, 1, 4'b0000);
        check("orphan protocol_err", 64'(protocol_err), 64'(1));
        check("orphan data held",    64'(rsp_data),     64'(16'h5B00));
        check("orphan error held",   64'(rsp_error),    64'(0));

        // Asynchronous reset mid-RUN while a response is on the outputs
        drive("midrst a", 4'b0001, 16'h6000, 1, 0, 0, '0, 0, 4'b0001);
        drive("midrst b", 4'b0001, 16'h6000, 1, 0, 0, '0, 0, 4'b0001);
        drive("midrst result", 4'b0000, 16'h6000, 1, 0, 1, 16'h0555, 1, 4'b0000);
        req_valid = '0; eng_out_valid = 0; eng_error = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async rsp_valid",    64'(rsp_valid),    64'(0));
        check("async rsp_data",     64'(rsp_data),     64'(0));
        check("async rsp_error",    64'(rsp_error),    64'(0));
        check("async protocol_err", 64'(protocol_err), 64'(0));
        check("async busy",         64'(busy),         64'(0));
        tag_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive("late result", 4'b0000, 16'h6000, 1, 0, 1, 16'h0777, 0, 4'b0000);
        check("late protocol_err", 64'(protocol_err), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/series_arbiter.md
# series_arbiter

Round-robin arbiter and scheduler that shares one in-order, pipelined series-evaluation engine between NREQ requesters. It grants one operand per cycle to the engine, records the issuing requester's tag in an in-order tag FIFO, and routes each engine result back to its originator. It also supports a flush/drain sequence and flags protocol errors. It sits between the per-channel request logic and the engine's controller/datapath.

## Interface
- NREQ, 4, number of requesters (power of two, 2..8)
- DW, 16, operand/result width
- DEPTH, 8, tag FIFO depth; must be at least the engine's maximum in-flight count
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  requester i has an operand
- req_data  input  NREQ*DW  operand of requester i at bits [i*DW +: DW]
- req_ready  output  NREQ  one-hot grant; handshake when req_valid[i] && req_ready[i]
- flush  input  1  single-cycle pulse; stop issuing and drain in-flight work
- eng_ready  input  1  engine accepts an operand this cycle
- eng_start  output  1  issue strobe to engine
- eng_x  output  DW  operand to engine, valid with eng_start
- eng_out_valid  input  1  engine result valid (in issue order)
- eng_result  input  DW  engine result
- eng_error  input  1  engine overflow/error, qualified by eng_out_valid
- rsp_valid  output  NREQ  one-hot, result for requester i
- rsp_data  output  DW  result, valid with any rsp_valid bit
- rsp_error  output  1  error bit of the returned result
- busy  output  1  state != IDLE
- protocol_err  output  1  sticky; eng_out_valid seen with empty tag FIFO

## Operation
- States: IDLE (FIFO empty), RUN (work in flight or being issued), DRAIN (flush accepted, issue blocked).
- Issue is allowed when state != DRAIN, eng_ready=1, and the FIFO is not full, or is full with a pop in the same cycle.
- Grant: when issue is allowed, req_ready is the first requester with req_valid set, searching from pointer ptr upward with wrap modulo NREQ. Otherwise req_ready=0.
- eng_start = |(req_valid & req_ready). eng_x = req_data of the granted requester; eng_x = 0 when there is no grant.
- On issue: push the grant tag (log2 NREQ bits) and set ptr <= granted index + 1 (mod NREQ). ptr is unchanged without an issue.
- On eng_out_valid with the FIFO non-empty: pop the head tag and register the response.
  - rsp_valid[tag] <= 1, rsp_data <= eng_result, rsp_error <= eng_error.
  - Otherwise rsp_valid <= 0. rsp_data and rsp_error hold their values.
- eng_out_valid with the FIFO empty: the result is dropped, no rsp_valid, and protocol_err <= 1. protocol_err is cleared only by reset.
- A push and a pop in the same cycle leave the count unchanged. The count range is 0..DEPTH.
- Transitions:
  - IDLE->RUN on issue.
  - RUN->IDLE when next count = 0.
  - IDLE/RUN->DRAIN on flush when next count != 0. Flush with next count = 0 goes to IDLE.
  - DRAIN->IDLE when next count = 0.
- flush has priority over an issue in the same cycle: no grant in that cycle.

## Timing
- Reset values (async, rst_n=0):
  - state IDLE, ptr 0, FIFO count 0.
  - rsp_valid 0, rsp_data 0, rsp_error 0, protocol_err 0, busy 0.
- req_ready and eng_start are combinational from inputs, ptr, count and state. There is no registered grant, so zero-cycle issue latency.
- Response latency: rsp_valid rises 1 cycle after the eng_out_valid cycle. rsp_valid is a single-cycle pulse per result, with no backpressure on responses.
- Throughput: 1 issue per cycle while eng_ready=1 and the FIFO has room.
- Reset asserted mid-operation discards all tags. Results that arrive after reset release with an empty FIFO set protocol_err.

## Test plan
- Single request: after reset, req_valid=0001, data 0x0100, eng_ready=1 -> req_ready=0001 and eng_start=1 with eng_x=0x0100 in the same cycle. Drive eng_out_valid with result 0x02B8 3 cycles later -> next cycle rsp_valid=0001, rsp_data=0x02B8, busy falls.
- Round-robin: req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Results returned in order route to rsp_valid 0001,0010,0100,1000,...
- FIFO full: eng_ready=1, no engine results, DEPTH=8 -> exactly 8 issues, then req_ready=0. One eng_out_valid frees a slot -> the issue resumes in the same cycle as the pop.
- Flush: 3 in flight, pulse flush with req_valid=1111 -> state DRAIN, req_ready=0. After 3 results, rsp_valid pulses 3 times, then IDLE and busy=0.
- Error routing: eng_out_valid with eng_error=1 for tag 2 -> rsp_valid=0100 and rsp_error=1.
- Protocol error and reset: eng_out_valid with an empty FIFO -> protocol_err=1 and no rsp_valid. Pulse rst_n low mid-RUN -> all registered outputs return to 0 immediately.
